lamp_fpu_log_iter: RTL and testbench
====================================

# lamp_fpu_log_iter

Parametrised multi-cycle logarithm unit for the lampFPU datapath: the next-generation successor of the single-mode bfloat16 log stage. It accepts an unpacked float (sign, exponent, fraction plus class flags), computes log2, ln or log10 by iterative mantissa squaring followed by a constant scale, and returns a rounded, packed-field result. The unit sits beside the other lampFPU arithmetic units, behind the same operand-unpack stage, and uses a start/valid handshake.

## Interface
- LAMP_FLOAT_E_DW, 8: exponent width; BIAS = 2^(E_DW-1)-1.
- LAMP_FLOAT_F_DW, 7: stored fraction width.
- LOG_ITERS, F_DW+3: fractional log2 bits produced, one per iteration cycle.
- CONST_FW, LOG_ITERS+2: fraction bits of the ln2 and log10(2) constants.
- clk  in  1  clock; all flops on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- doLog_i  in  1  start; sampled only while ready_o=1.
- mode_i  in  2  operation: 00 log2, 01 ln, 10 log10, 11 reserved (treated as log2).
- s_op_i, e_op_i, f_op_i  in  1/E_DW/F_DW  operand fields.
- isZ_op_i, isInf_op_i, isSNAN_op_i, isQNAN_op_i  in  1 each  operand class.
- ready_o  out  1  idle, can accept.
- valid_o  out  1  one-cycle result strobe.
- s_res_o, e_res_o, f_res_o  out  1/E_DW/F_DW  result fields.
- isInvalid_o  out  1  invalid operation (negative non-zero, sNaN).
- isInexact_o  out  1  rounded result differs from the computed value.

## Operation
- FSM states: IDLE, ITER, SCALE, NORM, DONE. ready_o=1 only in IDLE.
- IDLE: on doLog_i, capture operand and mode. Special classes go to DONE; otherwise go to ITER with the counter at LOG_ITERS-1.
- Special results, in priority order:
  - sNaN: qNaN, invalid=1.
  - qNaN: qNaN, invalid=0.
  - Zero, or subnormal (e_op_i=0, flushed): -inf.
  - Negative non-zero: qNaN, invalid=1.
  - +inf: +inf.
- qNaN encoding: s=0, e=all ones, f=MSB only.
- Integer part: I = e_op_i - BIAS, signed E_DW+1 bits.
- ITER: y register holds 1.f with Y_FW = F_DW+LOG_ITERS fraction bits, initialised to 1.f_op_i.
  - Each cycle: y <= y*y, truncated to Y_FW bits.
  - If y*y >= 2, emit fraction bit 1 and halve y; else emit 0. Bits are emitted MSB first.
  - When the counter reaches 0, go to SCALE.
- SCALE: L = I concatenated with the LOG_ITERS fraction bits, in two's complement.
  - log2: pass L through.
  - ln and log10: multiply L by ln2 or log10(2) (CONST_FW bits, rounded to nearest), keeping full product width.
- NORM:
  - Result sign = product sign; take the magnitude.
  - Leading-one detect, then shift so the MSB lands at the hidden-bit position.
  - e_res = BIAS + MSB weight.
  - Round to nearest-even using guard plus the sticky OR of all remaining bits. A mantissa carry-out increments e_res.
  - isInexact_o = guard|sticky.
  - A magnitude of exactly 0 (operand 1.0) gives +0 with inexact=0.
- DONE: valid_o=1 for one cycle, outputs updated on the same edge, then IDLE.
- Result outputs and flags hold their last value until the next DONE. Overflow and underflow are impossible for these formats, so no flags are provided for them.
- doLog_i while ready_o=0: ignored, no queueing.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, ready_o=1, valid_o=0, all result fields and flags 0, counters and y cleared.
- Reset asserted mid-operation aborts it: no valid_o, nothing retained.
- Accept on edge k (doLog_i=1, ready_o=1). From edge k+1, ready_o=0.
- Special operand: DONE after edge k+1; valid_o high in cycle k+1..k+2.
- Normal operand: ITER spans LOG_ITERS cycles, then SCALE then NORM. valid_o is high for the cycle after edge k+LOG_ITERS+3. With defaults (LOG_ITERS=10) that is a 13-cycle latency.
- ready_o returns to 1 on the edge that clears valid_o. The earliest next accept is one cycle after the valid_o cycle.

## Test plan
- log2, operand 0x4000 (2.0) -> 0x3F80 (+1.0), inexact=0, invalid=0, valid_o exactly 13 cycles after accept; 0x4100 (8.0) -> 0x4040.
- log2, operand 0x3F00 (0.5) -> 0xBF80 (-1.0); ln, operand 0x3F80 (1.0) -> 0x0000, inexact=0.
- ln, operand 0x4000 -> 0x3F31 (0.6914), inexact=1; compare all positive normal operands against a reference model, error ≤0.5 ulp.
- Specials, each valid_o 1 cycle after accept:
  - 0x0000 -> 0xFF80.
  - 0x0001 (subnormal) -> 0xFF80.
  - 0xBF80 -> 0x7FC0 with invalid=1.
  - +inf -> 0x7F80.
  - sNaN -> 0x7FC0 with invalid=1.
  - qNaN -> 0x7FC0 with invalid=0.
- Pulse doLog_i during ITER with another operand -> ignored, first result unaffected. Back-to-back accepts at the earliest ready_o cycle -> both results correct.
- Deassert rst during cycle 5 of ITER -> outputs 0 and ready_o=1 immediately, no valid_o. The next operation completes correctly.

Source files
------------

// File: rtl/lamp_fpu_log_iter.sv
// lamp_fpu_log_iter: multi-cycle log2 / ln / log10 unit for the lampFPU datapath.
// It computes the fractional part of log2 by repeated mantissa squaring, one bit
// per cycle, then applies a constant scale for ln/log10. Finally it normalises
// and rounds the result into packed sign/exponent/fraction fields.
module lamp_fpu_log_iter #(
    parameter int LAMP_FLOAT_E_DW = 8,
    parameter int LAMP_FLOAT_F_DW = 7,
    parameter int LOG_ITERS       = LAMP_FLOAT_F_DW + 3,
    parameter int CONST_FW        = LOG_ITERS + 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       doLog_i,
    input  logic [1:0]                 mode_i,
    input  logic                       s_op_i,
    input  logic [LAMP_FLOAT_E_DW-1:0] e_op_i,
    input  logic [LAMP_FLOAT_F_DW-1:0] f_op_i,
    input  logic                       isZ_op_i,
    input  logic                       isInf_op_i,
    input  logic                       isSNAN_op_i,
    input  logic                       isQNAN_op_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic                       s_res_o,
    output logic [LAMP_FLOAT_E_DW-1:0] e_res_o,
    output logic [LAMP_FLOAT_F_DW-1:0] f_res_o,
    output logic                       isInvalid_o,
    output logic                       isInexact_o
);

    localparam int E_DW  = LAMP_FLOAT_E_DW;
    localparam int F_DW  = LAMP_FLOAT_F_DW;
    localparam int BIAS  = (1 << (E_DW - 1)) - 1;
    localparam int Y_FW  = F_DW + LOG_ITERS;       // fraction bits of the squaring register
    localparam int YW    = Y_FW + 1;               // plus the integer bit
    localparam int SQW   = 2 * YW;                 // full square width
    localparam int IW    = E_DW + 1;               // signed integer part of log2
    localparam int LW    = IW + LOG_ITERS;         // fixed-point log2 value
    localparam int KW    = CONST_FW + 2;           // signed scale constant (holds 1.0 too)
    localparam int PW    = LW + KW;                // full product width
    localparam int PF    = LOG_ITERS + CONST_FW;   // fraction bits of the product
    localparam int LZW   = $clog2(PW);
    localparam int CNT_W = $clog2(LOG_ITERS + 1);

    // Scale constants rounded to nearest at CONST_FW fraction bits; log2 uses exactly 1.0
    // so every mode shares the same product format.
    localparam real LN2_R    = 0.6931471805599453;
    localparam real LG2_R    = 0.3010299956639812;
    localparam int  LN2_INT  = $rtoi(LN2_R * (2.0 ** CONST_FW) + 0.5);
    localparam int  LG2_INT  = $rtoi(LG2_R * (2.0 ** CONST_FW) + 0.5);
    localparam logic signed [KW-1:0] LN2_K  = KW'(LN2_INT);
    localparam logic signed [KW-1:0] LG2_K  = KW'(LG2_INT);
    localparam logic signed [KW-1:0] LOG2_K = KW'(1 << CONST_FW);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ITER  = 3'd1,
        SCALE = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]        cnt;
    logic [YW-1:0]           y;
    logic [LOG_ITERS-1:0]    frac_bits;
    logic signed [IW-1:0]    int_part;
    logic [1:0]              mode_q;
    logic signed [PW-1:0]    prod;

    // Staged result, copied to the outputs when DONE retires.
    logic                    res_s;
    logic [E_DW-1:0]         res_e;
    logic [F_DW-1:0]         res_f;
    logic                    res_inv;
    logic                    res_inx;

    logic accept;
    assign ready_o = (state == IDLE) && !valid_o;
    assign accept  = doLog_i && ready_o;

    // Special-operand classification, evaluated on the incoming operand.
    logic            spec_hit;
    logic            spec_s;
    logic [E_DW-1:0] spec_e;
    logic [F_DW-1:0] spec_f;
    logic            spec_inv;

    // Special class priority: sNaN, qNaN, zero/subnormal, negative, +inf.
    always_comb begin
        spec_hit = 1'b1;
        spec_s   = 1'b0;
        spec_e   = '1;
        spec_f   = {1'b1, {(F_DW-1){1'b0}}};
        spec_inv = 1'b0;
        if (isSNAN_op_i) begin
            spec_inv = 1'b1;
        end else if (isQNAN_op_i) begin
            spec_inv = 1'b0;
        end else if (isZ_op_i || (e_op_i == '0)) begin
            spec_s = 1'b1;
            spec_f = '0;
        end else if (s_op_i) begin
            spec_inv = 1'b1;
        end else if (isInf_op_i) begin
            spec_f = '0;
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Squaring step: y in [1,2) so y*y lies in [1,4); bit SQW-1 flags y*y >= 2.
    logic [SQW-1:0] sq;
    logic           sq_ge2;
    logic [YW-1:0]  y_nxt;
    assign sq     = SQW'(y) * SQW'(y);
    assign sq_ge2 = sq[SQW-1];
    assign y_nxt  = sq_ge2 ? sq[SQW-1 -: YW] : sq[SQW-2 -: YW];

    // Scale: signed fixed-point log2 times the mode constant, full width kept.
    logic signed [LW-1:0] l_val;
    logic signed [KW-1:0] k_sel;
    logic signed [PW-1:0] l_ext;
    logic signed [PW-1:0] k_ext;
    logic signed [PW-1:0] prod_nxt;

    // Mode constant select; the reserved encoding behaves as log2.
    always_comb begin
        k_sel = LOG2_K;
        case (mode_q)
            2'b01:   k_sel = LN2_K;
            2'b10:   k_sel = LG2_K;
            default: k_sel = LOG2_K;
        endcase
    end

    assign l_val    = {int_part, frac_bits};
    assign l_ext    = {{(PW-LW){l_val[LW-1]}}, l_val};
    assign k_ext    = {{(PW-KW){k_sel[KW-1]}}, k_sel};
    assign prod_nxt = l_ext * k_ext;

    // Normalisation and round-to-nearest-even of the product magnitude.
    logic [PW-1:0]   mag;
    logic [LZW-1:0]  lead;
    logic [LZW-1:0]  shamt;
    logic [PW-1:0]   norm;
    logic [F_DW-1:0] mant_frac;
    logic            guard;
    logic            sticky;
    logic            rnd_up;
    logic [F_DW:0]   mant_sum;
    logic            n_s;
    logic [E_DW-1:0] n_e;
    logic [F_DW-1:0] n_f;
    logic            n_inx;
    int              e_calc;

    // Leading-one detect, shift to hidden-bit position, round, build fields.
    always_comb begin
        mag = prod[PW-1] ? $unsigned(-prod) : $unsigned(prod);
        lead = '0;
        for (int i = 0; i < PW; i++) begin
            if (mag[i]) lead = i[LZW-1:0];
        end
        shamt     = LZW'(PW - 1) - lead;
        norm      = mag << shamt;
        mant_frac = norm[PW-2 -: F_DW];
        guard     = norm[PW-2-F_DW];
        sticky    = |norm[PW-3-F_DW:0];
        rnd_up    = guard & (sticky | mant_frac[0]);
        mant_sum  = {1'b0, mant_frac} + {{F_DW{1'b0}}, rnd_up};
        e_calc    = BIAS - PF + int'(lead) + int'(mant_sum[F_DW]);
        n_s       = prod[PW-1];
        n_e       = e_calc[E_DW-1:0];
        n_f       = mant_sum[F_DW-1:0];
        n_inx     = guard | sticky;
        if (mag == '0) begin
            n_s   = 1'b0;
            n_e   = '0;
            n_f   = '0;
            n_inx = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = spec_hit ? DONE : ITER;
            ITER:    if (cnt == '0) state_nxt = SCALE;
            SCALE:   state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, scaling, staged result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            y         <= '0;
            frac_bits <= '0;
            int_part  <= '0;
            mode_q    <= '0;
            prod      <= '0;
            res_s     <= 1'b0;
            res_e     <= '0;
            res_f     <= '0;
            res_inv   <= 1'b0;
            res_inx   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mode_q    <= mode_i;
                        int_part  <= $signed({1'b0, e_op_i} - IW'(BIAS));
                        y         <= {1'b1, f_op_i, {LOG_ITERS{1'b0}}};
                        frac_bits <= '0;
                        cnt       <= CNT_W'(LOG_ITERS - 1);
                        if (spec_hit) begin
                            res_s   <= spec_s;
                            res_e   <= spec_e;
                            res_f   <= spec_f;
                            res_inv <= spec_inv;
                            res_inx <= 1'b0;
                        end
                    end
                end
                ITER: begin
                    y         <= y_nxt;
                    frac_bits <= {frac_bits[LOG_ITERS-2:0], sq_ge2};
                    cnt       <= cnt - 1'b1;
                end
                SCALE: begin
                    prod <= prod_nxt;
                end
                NORM: begin
                    res_s   <= n_s;
                    res_e   <= n_e;
                    res_f   <= n_f;
                    res_inv <= 1'b0;
                    res_inx <= n_inx;
                end
                default: begin
                end
            endcase
        end
    end

    // Output registers: updated together with the one-cycle valid strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o     <= 1'b0;
            s_res_o     <= 1'b0;
            e_res_o     <= '0;
            f_res_o     <= '0;
            isInvalid_o <= 1'b0;
            isInexact_o <= 1'b0;
        end else begin
            valid_o <= (state == DONE);
            if (state == DONE) begin
                s_res_o     <= res_s;
                e_res_o     <= res_e;
                f_res_o     <= res_f;
                isInvalid_o <= res_inv;
                isInexact_o <= res_inx;
            end
        end
    end

endmodule

// File: tb/tb_lamp_fpu_log_iter.sv
// Testbench for lamp_fpu_log_iter: directed steps plus a random sweep, with a
// scoreboard queue of expected results checked when valid_o fires.
module tb_lamp_fpu_log_iter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       doLog = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       s_op = 1'b0;
    logic [7:0] e_op = '0;
    logic [6:0] f_op = '0;
    logic       isZ = 1'b0, isInf = 1'b0, isS = 1'b0, isQ = 1'b0;
    logic       ready, valid, s_res, inv, inx;
    logic [7:0] e_res;
    logic [6:0] f_res;

    lamp_fpu_log_iter dut (
        .clk(clk), .rst(rst), .doLog_i(doLog), .mode_i(mode),
        .s_op_i(s_op), .e_op_i(e_op), .f_op_i(f_op),
        .isZ_op_i(isZ), .isInf_op_i(isInf), .isSNAN_op_i(isS), .isQNAN_op_i(isQ),
        .ready_o(ready), .valid_o(valid),
        .s_res_o(s_res), .e_res_o(e_res), .f_res_o(f_res),
        .isInvalid_o(inv), .isInexact_o(inx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] res;
        logic        iv;
        logic        ix;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: the iterative log2 bits, an exact real-valued scaled product,
    // then independent real-arithmetic normalisation and RNE rounding.
    function automatic void model(input logic [15:0] op, input logic [1:0] md,
                                  output logic [15:0] res, output logic iv, output logic ix);
        logic [7:0] e;
        logic [6:0] f;
        longint y, sq, lint, k;
        int fr, ex, fi;
        real v, m, sc, fl, rem;
        logic sg;
        e = op[14:7];
        f = op[6:0];
        iv = 1'b0;
        ix = 1'b0;
        res = 16'h0000;
        if (e == 8'hFF && f != 0 && !f[6]) begin res = 16'h7FC0; iv = 1'b1; end
        else if (e == 8'hFF && f[6]) res = 16'h7FC0;
        else if (e == 8'h00) res = 16'hFF80;
        else if (op[15]) begin res = 16'h7FC0; iv = 1'b1; end
        else if (e == 8'hFF) res = 16'h7F80;
        else begin
            y  = (longint'(1) << 17) | (longint'(f) << 10);
            fr = 0;
            for (int i = 0; i < 10; i++) begin
                sq = y * y;
                if (sq >= (longint'(1) << 35)) begin fr = fr * 2 + 1; y = sq >> 18; end
                else begin fr = fr * 2; y = sq >> 17; end
            end
            lint = (longint'(e) - 127) * 1024 + longint'(fr);
            k = (md == 2'b01) ? 2839 : (md == 2'b10) ? 1233 : 4096;
            v = real'(lint * k) / 4194304.0;
            if (v != 0.0) begin
                sg = (v < 0.0);
                m  = sg ? -v : v;
                ex = 0;
                while (m >= 2.0) begin m = m / 2.0; ex++; end
                while (m < 1.0) begin m = m * 2.0; ex--; end
                sc  = m * 128.0;
                fl  = $floor(sc);
                rem = sc - fl;
                fi  = $rtoi(fl);
                ix  = (rem != 0.0);
                if (rem > 0.5 || (rem == 0.5 && fi[0])) fi++;
                if (fi == 256) begin fi = 128; ex++; end
                res = {sg, 8'(ex + 127), 7'(fi - 128)};
            end
        end
    endfunction

    task automatic drive(input logic [15:0] op, input logic [1:0] md);
        @(negedge clk);
        mode  = md;
        s_op  = op[15];
        e_op  = op[14:7];
        f_op  = op[6:0];
        isZ   = (op[14:0] == 15'd0);
        isInf = (op[14:7] == 8'hFF) && (op[6:0] == 7'd0);
        isQ   = (op[14:7] == 8'hFF) && op[6];
        isS   = (op[14:7] == 8'hFF) && (op[6:0] != 7'd0) && !op[6];
        doLog = 1'b1;
    endtask

    task automatic issue(input logic [15:0] op, input logic [1:0] md, input logic [15:0] r,
                         input logic iv, input logic ix, input int lat);
        exp_t e;
        drive(op, md);
        chk("ready_before_accept", ready, 1);
        @(posedge clk);
        #1;
        doLog = 1'b0;
        e.res = r; e.iv = iv; e.ix = ix; e.lat = lat; e.acc = cyc;
        sb.push_back(e);
        chk("ready_low_after_accept", ready, 0);
    endtask

    task automatic collect(input string tag);
        exp_t e;
        int n;
        n = 0;
        while (valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_valid_seen"}, valid === 1'b1, 1);
        if (valid === 1'b1) begin
            chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({tag, "_res"}, {s_res, e_res, f_res}, e.res);
                chk({tag, "_invalid"}, inv, e.iv);
                chk({tag, "_inexact"}, inx, e.ix);
                if (e.lat >= 0) chk({tag, "_latency"}, cyc - e.acc, e.lat);
            end
            @(posedge clk);
            #1;
            chk({tag, "_valid_one_cycle"}, valid, 0);
            chk({tag, "_ready_back"}, ready, 1);
        end
    endtask

    task automatic run_model(input string tag, input logic [15:0] op, input logic [1:0] md, input int lat);
        logic [15:0] r;
        logic iv, ix;
        model(op, md, r, iv, ix);
        issue(op, md, r, iv, ix, lat);
        collect(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        logic [15:0] op;
        logic [1:0]  md;

        // Reset state
        #2 rst = 1'b0;
        #20;
        chk("reset_ready", ready, 1);
        chk("reset_valid", valid, 0);
        chk("reset_res", {s_res, e_res, f_res}, 16'h0000);
        chk("reset_flags", {inv, inx}, 2'b00);
        @(negedge clk);
        rst = 1'b1;

        // Directed normal operands, back-to-back at the earliest ready cycle
        issue(16'h4000, 2'b00, 16'h3F80, 1'b0, 1'b0, 13); collect("log2_2");
        issue(16'h4100, 2'b00, 16'h4040, 1'b0, 1'b0, 13); collect("log2_8");
        issue(16'h3F00, 2'b00, 16'hBF80, 1'b0, 1'b0, 13); collect("log2_half");
        issue(16'h3F80, 2'b01, 16'h0000, 1'b0, 1'b0, 13); collect("ln_1");
        issue(16'h4000, 2'b01, 16'h3F31, 1'b0, 1'b1, 13); collect("ln_2");
        issue(16'h4000, 2'b11, 16'h3F80, 1'b0, 1'b0, 13); collect("rsvd_mode_2");

        // Special operands
        issue(16'h0000, 2'b00, 16'hFF80, 1'b0, 1'b0, 1); collect("zero");
        issue(16'h0001, 2'b01, 16'hFF80, 1'b0, 1'b0, 1); collect("subnormal");
        issue(16'hBF80, 2'b00, 16'h7FC0, 1'b1, 1'b0, 1); collect("neg_one");
        issue(16'h7F80, 2'b10, 16'h7F80, 1'b0, 1'b0, 1); collect("pos_inf");
        issue(16'hFF80, 2'b00, 16'h7FC0, 1'b1, 1'b0, 1); collect("neg_inf");
        issue(16'h7F81, 2'b00, 16'h7FC0, 1'b1, 1'b0, 1); collect("snan");
        issue(16'h7FC0, 2'b00, 16'h7FC0, 1'b0, 1'b0, 1); collect("qnan");

        // Boundary operands through the reference model
        run_model("min_normal_ln", 16'h0080, 2'b01, 13);
        run_model("max_normal_log10", 16'h7F7F, 2'b10, 13);
        run_model("just_above_one", 16'h3F81, 2'b00, 13);
        run_model("just_below_one_ln", 16'h3F7F, 2'b01, 13);
        run_model("log10_2", 16'h4000, 2'b10, 13);

        // doLog during ITER is ignored
        issue(16'h4100, 2'b00, 16'h4040, 1'b0, 1'b0, 13);
        repeat (4) @(posedge clk);
        drive(16'h4000, 2'b01);
        @(negedge clk);
        doLog = 1'b0;
        collect("ignore_busy");
        nv = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) nv++;
        end
        chk("no_extra_valid", nv, 0);
        chk("result_holds", {s_res, e_res, f_res}, 16'h4040);

        // Reset during ITER cycle 5 aborts the operation
        issue(16'h4000, 2'b01, 16'h3F31, 1'b0, 1'b1, 13);
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_valid", valid, 0);
        chk("abort_res", {s_res, e_res, f_res}, 16'h0000);
        chk("abort_flags", {inv, inx}, 2'b00);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        nv = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) nv++;
        end
        chk("abort_no_valid", nv, 0);
        issue(16'h4000, 2'b01, 16'h3F31, 1'b0, 1'b1, 13); collect("after_abort");

        // Random positive normal operands in all modes
        for (int i = 0; i < 150; i++) begin
            op = {1'b0, 8'($urandom_range(254, 1)), 7'($urandom_range(127, 0))};
            md = 2'($urandom_range(3, 0));
            run_model("rand", op, md, 13);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
